// File: rtl/seg7_out_driver.sv
// Latches OUT-instruction writes and scans them as four hex digits on a
// multiplexed 7-segment display, blinking the decimal points while halted.
module seg7_out_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_we,
  input  logic [15:0] out_data,
  input  logic        lz_en,
  input  logic        hlt,
  output logic [7:0]  seg,
  output logic [3:0]  digit_sel
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ROUND_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [15:0]        data_q, data_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
  logic               blink_q, blink_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         digit_sel_q, digit_sel_d;

  logic               scan_tc;
  logic               round_tc;
  logic [3:0]         nibble;
  logic               blank;

  // Segment pattern a..g for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b0001101;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // Scan timing, data latch and blink state.
  always_comb begin
    data_d      = data_q;
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    idx_d       = idx_q;
    round_cnt_d = round_cnt_q;
    blink_d     = blink_q;

    scan_tc  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    round_tc = (round_cnt_q == ROUND_W'(BLINK_DIV - 1));

    if (out_we) begin
      data_d = out_data;
    end

    if (scan_tc) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        if (round_tc) begin
          round_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          round_cnt_d = round_cnt_q + ROUND_W'(1);
        end
      end
    end
  end

  // Digit k is blanked when all nibbles at or above k are zero; digit 0 never is.
  always_comb begin
    nibble = data_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    blank = (data_q[15:4] == 12'd0);
      2'd2:    blank = (data_q[15:8] == 8'd0);
      2'd3:    blank = (data_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    blank = blank & lz_en;
  end

  // Output pattern; the first cycle of every digit is dark to avoid ghosting.
  always_comb begin
    seg_d       = 8'h00;
    digit_sel_d = 4'(4'b0001 << idx_q);
    if (scan_cnt_q != '0) begin
      seg_d[7:1] = blank ? 7'd0 : glyph(nibble);
      seg_d[0]   = hlt & blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      round_cnt_q <= '0;
      blink_q     <= 1'b0;
      seg_q       <= 8'h00;
      digit_sel_q <= 4'b0000;
    end else begin
      data_q      <= data_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      round_cnt_q <= round_cnt_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg7_out_driver.sv
// Bench for seg7_out_driver: arithmetic model of the scan timeline checked every
// cycle, plus directed literal expectations and a randomized phase.
module tb_seg7_out_driver;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_we;
  logic [15:0] out_data;
  logic        lz_en;
  logic        hlt;
  logic [7:0]  seg;
  logic [3:0]  digit_sel;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_cmp = 1'b0;

  seg7_out_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .out_we(out_we), .out_data(out_data),
    .lz_en(lz_en), .hlt(hlt), .seg(seg), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tbl [0:15] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

  // Model: edges since reset determine scan position and blink phase directly.
  int          t_m = 0;
  logic [15:0] data_m = '0;
  logic [7:0]  exp_seg = 8'h00;
  logic [3:0]  exp_dig = 4'h0;

  always @(posedge clk or posedge rst) begin
    int scan, idx, blk, upper;
    if (rst) begin
      t_m = 0; data_m = '0; exp_seg = 8'h00; exp_dig = 4'h0;
    end else begin
      scan  = t_m % SCAN_DIV;
      idx   = (t_m / SCAN_DIV) % 4;
      blk   = (t_m / (4 * SCAN_DIV * BLINK_DIV)) % 2;
      upper = int'(data_m >> (4 * idx));
      exp_dig = 4'(1 << idx);
      if (scan == 0) exp_seg = 8'h00;
      else begin
        exp_seg = glyph_tbl[upper % 16] & 8'hFE;
        if (lz_en && idx >= 1 && upper == 0) exp_seg = 8'h00;
        exp_seg[0] = hlt & (blk == 1);
      end
      if (out_we) data_m = out_data;
      t_m++;
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_seg", {8'h00, seg}, {8'h00, exp_seg});
      check("model_digit_sel", {12'h000, digit_sel}, {12'h000, exp_dig});
    end
  end

  task automatic wr(input logic [15:0] d);
    @(negedge clk); #1; out_we = 1'b1; out_data = d;
    @(negedge clk); #1; out_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
  endtask

  // Glyph on the second cycle of the next fresh selection of digit 'sel'.
  task automatic digit_glyph(input string nm, input logic [3:0] sel, input logic [7:0] expv);
    int n = 0;
    while (digit_sel == sel && n < 40) begin @(negedge clk); n++; end
    while (digit_sel != sel && n < 80) begin @(negedge clk); n++; end
    if (n >= 80) begin
      check({nm, "_timeout"}, 16'd1, 16'd0);
    end else begin
      @(negedge clk);
      check(nm, {8'h00, seg}, {8'h00, expv});
    end
  endtask

  initial begin
    rst = 1'b0; out_we = 1'b0; out_data = '0; lz_en = 1'b0; hlt = 1'b0;
    #2 rst = 1'b1;
    run_cmp = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg", {8'h00, seg}, 16'h0000);
    check("rst_digit_sel", {12'h000, digit_sel}, 16'h0000);
    #1 rst = 1'b0;
    @(negedge clk);
    check("edge1_seg", {8'h00, seg}, 16'h0000);
    check("edge1_digit_sel", {12'h000, digit_sel}, 16'h0001);
    @(negedge clk);
    check("edge2_seg", {8'h00, seg}, 16'h00FC);
    check("edge2_digit_sel", {12'h000, digit_sel}, 16'h0001);

    wr(16'hA5C3);
    digit_glyph("a5c3_d0", 4'b0001, 8'hF2);
    digit_glyph("a5c3_d1", 4'b0010, 8'h1A);
    digit_glyph("a5c3_d2", 4'b0100, 8'hB6);
    digit_glyph("a5c3_d3", 4'b1000, 8'hEE);

    lz_en = 1'b1;
    wr(16'h0040);
    digit_glyph("lz40_d3", 4'b1000, 8'h00);
    digit_glyph("lz40_d2", 4'b0100, 8'h00);
    digit_glyph("lz40_d1", 4'b0010, 8'h66);
    digit_glyph("lz40_d0", 4'b0001, 8'hFC);
    wr(16'h0000);
    digit_glyph("lz0_d1", 4'b0010, 8'h00);
    digit_glyph("lz0_d0", 4'b0001, 8'hFC);
    lz_en = 1'b0;

    // Blink half-period of 32 cycles measured from reset release.
    hlt = 1'b1;
    pulse_reset();
    repeat (2) @(negedge clk);
    check("hlt_early_seg", {8'h00, seg}, 16'h00FC);
    repeat (32) @(negedge clk);
    check("hlt_blink_on_seg", {8'h00, seg}, 16'h00FD);
    #1 hlt = 1'b0;
    @(negedge clk);
    check("hlt_off_seg", {8'h00, seg}, 16'h00FC);

    @(negedge clk); #1; out_we = 1'b1; out_data = 16'h1111;
    @(negedge clk); #1; out_data = 16'h2222;
    @(negedge clk); #1; out_we = 1'b0;
    digit_glyph("last_wins_d0", 4'b0001, 8'hDA);
    digit_glyph("last_wins_d3", 4'b1000, 8'hDA);

    begin
      int n = 0;
      while (digit_sel != 4'b0100 && n < 40) begin @(negedge clk); n++; end
      check("find_digit2", {15'd0, n >= 40}, 16'd0);
    end
    @(negedge clk); #1;
    rst = 1'b1; out_we = 1'b1; out_data = 16'hFFFF;
    #1;
    check("midrst_seg", {8'h00, seg}, 16'h0000);
    check("midrst_digit_sel", {12'h000, digit_sel}, 16'h0000);
    @(negedge clk); #1; rst = 1'b0; out_we = 1'b0;
    @(negedge clk);
    check("post_rst_e1_seg", {8'h00, seg}, 16'h0000);
    check("post_rst_e1_digit_sel", {12'h000, digit_sel}, 16'h0001);
    @(negedge clk);
    check("post_rst_e2_seg", {8'h00, seg}, 16'h00FC);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      out_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       out_data = 16'($urandom);
        1:       out_data = 16'($urandom_range(0, 255));
        2:       out_data = 16'($urandom_range(0, 15));
        default: out_data = 16'h0000;
      endcase
      if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 30) == 0) hlt = ~hlt;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); #1; rst = 1'b0; out_we = 1'b0;
    repeat (4) @(negedge clk);
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_out_driver.md
# seg7_out_driver

Output-port display driver for the processor's OUT instruction. It latches each 16-bit OUT write and time-multiplexes the value as four hex digits on a common 4-digit 7-segment display. Digit glyphs match the ALU's OUT segment table. It also blinks the decimal points while the core is halted. It sits between the core's OUT write path and the board display pins.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays selected (≥2).
- BLINK_DIV, 64: number of complete 4-digit scan rounds per HLT blink half-period (≥1).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- out_we  in  1  write strobe from the OUT instruction; sampled every clk edge.
- out_data  in  16  value to display; captured when out_we=1.
- lz_en  in  1  1 = blank leading zero digits.
- hlt  in  1  core halted; enables dp blinking.
- seg  out  8  registered, active-high segments {a,b,c,d,e,f,g,dp} in bits 7..0.
- digit_sel  out  4  registered, one-hot, active-high digit enable; bit0 = least significant nibble.

## Operation
- data_reg (16 b): loaded with out_data on an edge where out_we=1. Back-to-back writes are accepted every cycle; the last write wins. There is no busy or backpressure.
- scan_cnt counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and idx advances 0→1→2→3→0.
- round_cnt increments when idx wraps 3→0 at terminal count. When it reaches BLINK_DIV-1 and increments, it wraps to 0 and the blink register toggles.
- Nibble for the current idx is data_reg[4*idx+3:4*idx]. Glyph table, segments a..g then dp=0:
  - 0 11111100, 1 01100000, 2 11011010, 3 11110010
  - 4 01100110, 5 10110110, 6 10111110, 7 11100000
  - 8 11111110, 9 11110110, A 11101110, b 00111110
  - c 00011010, d 01111010, E 10011110, F 10001110
- Leading-zero blanking applies when lz_en=1. Digit k (k≥1) shows seg[7:1]=0 if every nibble ≥k is zero. Digit 0 is never blanked, so value 0 shows "0".
- dp: seg[0] = hlt & blink on every digit, including blanked ones. When hlt=0, dp=0 and blink keeps running.
- Ghost suppression: on the cycle where scan_cnt=0, seg=8'h00 while digit_sel already shows the new digit.

## Timing
- Reset values: seg=8'h00, digit_sel=4'b0000, data_reg=0, idx=0, scan_cnt=0, round_cnt=0, blink=0.
- Outputs are registered. seg and digit_sel at edge N+1 are computed from idx, scan_cnt, data_reg, lz_en, hlt and blink as they stand after edge N.
- First edge after reset release: digit_sel=0001, seg=00 (blank cycle). Second edge: seg=glyph of nibble 0 (11111100 for data 0).
- A write captured at edge N is visible on seg at edge N+1 if its digit is active and scan_cnt≠0.
- Each digit is selected for exactly SCAN_DIV cycles. A full scan takes 4·SCAN_DIV cycles. Blink half-period is BLINK_DIV·4·SCAN_DIV cycles.
- A write at the same edge as a digit change or terminal count is captured normally; the scan is unaffected.
- A hlt change takes effect on the next edge's dp.
- rst asserted at any time, including mid-scan or mid-write, forces all registers to reset values immediately. A write coincident with rst is dropped.

## Test plan
Run with SCAN_DIV=4, BLINK_DIV=2, lz_en=0, hlt=0 unless stated.
- Reset release, no writes -> digit_sel=0001,0010,0100,1000 each for 4 cycles. Cycle 0 of each digit has seg=00; the others have seg=11111100.
- Write 16'hA5C3 -> over one round, digit0 seg=11110010 (3), digit1 00011010 (c), digit2 10110110 (5), digit3 11101110 (A). Change visible one cycle after the write.
- lz_en=1, write 16'h0040 -> digit3 seg=00, digit2 seg=00, digit1 01100110 (4), digit0 11111100 (0). Then write 16'h0000 -> only digit0 lit, showing 11111100.
- hlt=1 -> dp=0 for the first 32 cycles from reset, dp=1 on all digits for the next 32, then 0 again. hlt=0 -> dp=0 from the next edge.
- Writes 16'h1111 then 16'h2222 on consecutive cycles -> data_reg=16'h2222; no 16'h1111 glyph appears after the second write is visible.
- Assert rst mid-digit-2 together with out_we -> seg=00, digit_sel=0000 immediately. After release the scan restarts at digit 0 showing 0; the concurrent write is lost.
